// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI definitions: response/burst encodings, responder FSM states, bus widths.
package AXI_define;

    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_ID_BITS   = 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } axi_slave_state_e;

    function automatic logic req_unsupported(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || (burst == WRAP);
    endfunction

endpackage

// File: rtl/axi_sram_slave_sram.sv
// Single-port synchronous SRAM, 1-cycle read latency, per-byte write enable.
module sram_sp #(
    parameter int DATA_BITS   = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   en,
    input  logic [DATA_BITS/8-1:0] we,
    input  logic [IDX_W-1:0]       addr,
    input  logic [DATA_BITS-1:0]   wdata,
    output logic [DATA_BITS-1:0]   rdata
);

    logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

    // NOTE: the array itself is never reset so it maps onto a RAM macro; only the read register is.
    always_ff @(posedge ACLK) begin
        if (en) begin
            for (int b = 0; b < DATA_BITS/8; b++) begin
                if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)          rdata <= '0;
        else if (en && ~|we)   rdata <= mem[addr];
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder in front of a single-port SRAM; one FSM serialises reads and writes.
// Build option: define SRAM_BOUNDS_CHECK_EN to reject word indices >= DEPTH_WORDS with SLVERR.
module axi_sram_slave
    import AXI_define::*;
#(
    parameter int ID_BITS     = AXI_ID_BITS,
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = AXI_DATA_BITS,
    parameter int DEPTH_WORDS = 16384
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [ID_BITS-1:0]     AWID,
    input  logic [ADDR_BITS-1:0]   AWADDR,
    input  logic [7:0]             AWLEN,
    input  logic [2:0]             AWSIZE,
    input  logic [1:0]             AWBURST,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [DATA_BITS-1:0]   WDATA,
    input  logic [DATA_BITS/8-1:0] WSTRB,
    input  logic                   WLAST,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [ID_BITS-1:0]     BID,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
    input  logic [ID_BITS-1:0]     ARID,
    input  logic [ADDR_BITS-1:0]   ARADDR,
    input  logic [7:0]             ARLEN,
    input  logic [2:0]             ARSIZE,
    input  logic [1:0]             ARBURST,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [ID_BITS-1:0]     RID,
    output logic [DATA_BITS-1:0]   RDATA,
    output logic [1:0]             RRESP,
    output logic                   RLAST,
    output logic                   RVALID,
    input  logic                   RREADY
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    axi_slave_state_e       state_q, state_d;
    logic [ID_BITS-1:0]     id_q;
    logic [ADDR_BITS-1:0]   addr_q, addr_next;
    logic [7:0]             len_q, beat_q;
    logic [1:0]             burst_q, bresp_q, rresp_q;
    logic                   req_err_q, last_grant_wr_q;
    logic                   grant_rd, oob, beat_err, last_beat;
    logic                   sram_en;
    logic [DATA_BITS/8-1:0] sram_we;
    logic [DATA_BITS-1:0]   sram_rdata;

`ifdef SRAM_BOUNDS_CHECK_EN
    assign oob = |addr_q[ADDR_BITS-1:IDX_W+2];
`else
    assign oob = 1'b0;
`endif

    assign beat_err  = req_err_q | oob;
    assign last_beat = (beat_q == len_q);
    assign grant_rd  = ARVALID && (!AWVALID || last_grant_wr_q);

    // INCR only steps the word-index field, so bursts wrap inside the SRAM.
    always_comb begin
        addr_next = addr_q;
        if (burst_q == INCR) addr_next[IDX_W+1:2] = addr_q[IDX_W+1:2] + 1'b1;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        AWREADY = 1'b0;
        ARREADY = 1'b0;
        WREADY  = 1'b0;
        sram_en = 1'b0;
        sram_we = '0;
        case (state_q)
            IDLE: begin
                ARREADY = grant_rd;
                AWREADY = AWVALID && !grant_rd;
                if (ARREADY)      state_d = RD_ADDR;
                else if (AWREADY) state_d = WR_DATA;
            end
            RD_ADDR: begin
                sram_en = !beat_err;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (RREADY) state_d = last_beat ? IDLE : RD_ADDR;
            end
            WR_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    sram_en = !beat_err;
                    sram_we = beat_err ? '0 : WSTRB;
                    if (last_beat) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q         <= IDLE;
            id_q            <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            beat_q          <= '0;
            burst_q         <= INCR;
            req_err_q       <= 1'b0;
            bresp_q         <= OKAY;
            rresp_q         <= OKAY;
            last_grant_wr_q <= 1'b1;
        end else begin
            state_q <= state_d;
            // Only contested cycles move the round-robin pointer.
            if (state_q == IDLE && ARVALID && AWVALID) last_grant_wr_q <= !grant_rd;
            case (state_q)
                IDLE: begin
                    if (ARREADY) begin
                        id_q      <= ARID;
                        addr_q    <= ARADDR;
                        len_q     <= ARLEN;
                        burst_q   <= ARBURST;
                        beat_q    <= '0;
                        req_err_q <= req_unsupported(ARSIZE, ARBURST);
                    end else if (AWREADY) begin
                        id_q      <= AWID;
                        addr_q    <= AWADDR;
                        len_q     <= AWLEN;
                        burst_q   <= AWBURST;
                        beat_q    <= '0;
                        req_err_q <= req_unsupported(AWSIZE, AWBURST);
                        bresp_q   <= OKAY;
                    end
                end
                RD_ADDR: rresp_q <= beat_err ? SLVERR : OKAY;
                RD_DATA: begin
                    if (RREADY && !last_beat) begin
                        addr_q <= addr_next;
                        beat_q <= beat_q + 1'b1;
                    end
                end
                WR_DATA: begin
                    if (WVALID) begin
                        if (beat_err || (WLAST != last_beat)) bresp_q <= SLVERR;
                        addr_q <= addr_next;
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sram_sp #(
        .DATA_BITS   (DATA_BITS),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .en      (sram_en),
        .we      (sram_we),
        .addr    (addr_q[IDX_W+1:2]),
        .wdata   (WDATA),
        .rdata   (sram_rdata)
    );

    assign RVALID = (state_q == RD_DATA);
    assign RLAST  = RVALID && last_beat;
    assign RRESP  = rresp_q;
    assign RDATA  = (rresp_q == OKAY) ? sram_rdata : '0;
    assign RID    = id_q;
    assign BVALID = (state_q == WR_RESP);
    assign BRESP  = bresp_q;
    assign BID    = id_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave; honours SRAM_BOUNDS_CHECK_EN like the RTL.
module tb_axi_sram_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [7:0]  AWID = '0, ARID = '0;
    logic [31:0] AWADDR = '0, ARADDR = '0;
    logic [7:0]  AWLEN = '0, ARLEN = '0;
    logic [2:0]  AWSIZE = 3'd2, ARSIZE = 3'd2;
    logic [1:0]  AWBURST = 2'b01, ARBURST = 2'b01;
    logic        AWVALID = 1'b0, ARVALID = 1'b0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0, RREADY = 1'b0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
    logic [7:0]  BID, RID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ACLK = ~ACLK;

    axi_sram_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_ready(input string tag, input bit is_ar);
        int n = 0;
        #1;
        while (!(is_ar ? ARREADY : AWREADY) && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready"}, is_ar ? ARREADY : AWREADY, 1);
    endtask

    task automatic write_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [31:0] data0, input logic [31:0] inc,
                               input logic [3:0] strb, input bit wlast_bad, input logic [1:0] exp_resp);
        AWID = 8'h5A; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
        wait_ready(tag, 1'b0);
        step();
        AWVALID = 1'b0;
        check({tag, "_wready"}, WREADY, 1);
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1'b1; WDATA = data0 + i * inc; WSTRB = strb;
            WLAST = (i == int'(len)) ^ wlast_bad;
            step();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check({tag, "_bvalid"}, BVALID, 1);
        check({tag, "_bresp"}, BRESP, exp_resp);
        check({tag, "_bid"}, BID, 8'h5A);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check({tag, "_bdone"}, BVALID, 0);
    endtask

    task automatic read_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [31:0] data0,
                              input logic [31:0] inc, input logic [1:0] exp_resp, input bit stall);
        logic [31:0] exp_d;
        ARID = 8'hC3; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        wait_ready(tag, 1'b1);
        step();
        ARVALID = 1'b0;
        check({tag, "_rvalid_n1"}, RVALID, 0);
        for (int i = 0; i <= int'(len); i++) begin
            exp_d = (exp_resp == 2'b00) ? data0 + i * inc : 32'h0;
            step();
            check({tag, "_rvalid"}, RVALID, 1);
            check({tag, "_rdata"}, RDATA, exp_d);
            check({tag, "_rresp"}, RRESP, exp_resp);
            check({tag, "_rlast"}, RLAST, (i == int'(len)));
            check({tag, "_rid"}, RID, 8'hC3);
            if (stall) begin
                step();
                check({tag, "_stall_rdata"}, RDATA, exp_d);
                check({tag, "_stall_rlast"}, RLAST, (i == int'(len)));
                check({tag, "_stall_rresp"}, RRESP, exp_resp);
            end
            RREADY = 1'b1;
            step();
            RREADY = 1'b0;
            check({tag, "_rgap"}, RVALID, 0);
        end
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        step();
        step();
        ARESETn = 1'b1;
        step();
    endtask

    initial begin
        #2;
        check("rst_awready", AWREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_resp", {BRESP, RRESP}, 0);
        check("rst_ids", {BID, RID}, 0);
        do_reset();

        write_burst("single_wr", 32'h100, 8'd0, 2'b01, 32'hDEADBEEF, 0, 4'hF, 1'b0, 2'b00);
        read_burst("single_rd", 32'h100, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 0, 2'b00, 1'b0);

        write_burst("strb_pre", 32'h200, 8'd0, 2'b01, 32'h11223344, 0, 4'hF, 1'b0, 2'b00);
        write_burst("strb_wr", 32'h200, 8'd0, 2'b01, 32'hAABBCCDD, 0, 4'b0101, 1'b0, 2'b00);
        read_burst("strb_rd", 32'h200, 8'd0, 3'd2, 2'b01, 32'h11BB33DD, 0, 2'b00, 1'b0);

        write_burst("incr_wr", 32'h300, 8'd3, 2'b01, 32'd1, 1, 4'hF, 1'b0, 2'b00);
        read_burst("incr_rd", 32'h300, 8'd3, 3'd2, 2'b01, 32'd1, 1, 2'b00, 1'b1);

        write_burst("fixed_wr", 32'h500, 8'd1, 2'b00, 32'hA0, 32'h0B, 4'hF, 1'b0, 2'b00);
        read_burst("fixed_rd", 32'h500, 8'd0, 3'd2, 2'b01, 32'hAB, 0, 2'b00, 1'b0);

        write_burst("wlast_bad", 32'h600, 8'd0, 2'b01, 32'h600D, 0, 4'hF, 1'b1, 2'b10);
        read_burst("wlast_rd", 32'h600, 8'd0, 3'd2, 2'b01, 32'h600D, 0, 2'b00, 1'b0);

        read_burst("size_err", 32'h100, 8'd0, 3'd1, 2'b01, 32'h0, 0, 2'b10, 1'b0);
        read_burst("wrap_err", 32'h100, 8'd0, 3'd2, 2'b10, 32'h0, 0, 2'b10, 1'b0);

        write_burst("bnd_pre", 32'h0, 8'd0, 2'b01, 32'h5A5A5A5A, 0, 4'hF, 1'b0, 2'b00);
`ifdef SRAM_BOUNDS_CHECK_EN
        write_burst("bnd_wr", 32'h10000, 8'd0, 2'b01, 32'hCAFEF00D, 0, 4'hF, 1'b0, 2'b10);
        read_burst("bnd_rd", 32'h0, 8'd0, 3'd2, 2'b01, 32'h5A5A5A5A, 0, 2'b00, 1'b0);
`else
        write_burst("bnd_wr", 32'h10000, 8'd0, 2'b01, 32'hCAFEF00D, 0, 4'hF, 1'b0, 2'b00);
        read_burst("bnd_rd", 32'h0, 8'd0, 3'd2, 2'b01, 32'hCAFEF00D, 0, 2'b00, 1'b0);
`endif

        // Arbitration tie straight out of reset; SRAM contents survive reset.
        do_reset();
        ARADDR = 32'h100; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARID = 8'h11; ARVALID = 1'b1;
        AWADDR = 32'h400; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 8'h22; AWVALID = 1'b1;
        #1;
        check("tie1_arready", ARREADY, 1);
        check("tie1_awready", AWREADY, 0);
        step();
        ARVALID = 1'b0;
        check("tie1_busy_awready", AWREADY, 0);
        step();
        check("tie1_rdata", RDATA, 32'hDEADBEEF);
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check("tie1_awready_next", AWREADY, 1);
        step();
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; WLAST = 1'b1;
        step();
        WVALID = 1'b0; WLAST = 1'b0;
        check("tie1_bresp", {BVALID, BRESP}, 3'b100);
        check("tie1_bid", BID, 8'h22);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;

        ARADDR = 32'h400; ARID = 8'h33; ARVALID = 1'b1;
        AWADDR = 32'h404; AWID = 8'h44; AWVALID = 1'b1;
        #1;
        check("tie2_awready", AWREADY, 1);
        check("tie2_arready", ARREADY, 0);
        step();
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 32'h9; WLAST = 1'b1;
        step();
        WVALID = 1'b0; WLAST = 1'b0;
        check("tie2_bresp", {BVALID, BRESP}, 3'b100);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check("tie2_arready_next", ARREADY, 1);
        step();
        ARVALID = 1'b0;
        step();
        check("tie2_rdata", RDATA, 32'h12345678);
        check("tie2_rid", RID, 8'h33);
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;

        // Reset during beat 2 of a len-7 read.
        ARADDR = 32'h300; ARLEN = 8'd7; ARID = 8'h55; ARVALID = 1'b1;
        wait_ready("mid_rst", 1'b1);
        step();
        ARVALID = 1'b0;
        step();
        check("mid_rst_beat1", RDATA, 32'd1);
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        step();
        check("mid_rst_beat2", {RVALID, RLAST, RDATA[7:0]}, {1'b1, 1'b0, 8'd2});
        ARESETn = 1'b0;
        #1;
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_rlast", RLAST, 0);
        check("mid_rst_readies", {ARREADY, AWREADY, WREADY, BVALID}, 0);
        step();
        ARESETn = 1'b1;
        step();
        read_burst("post_rst_rd", 32'h100, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
